// File: rtl/ela_deinterlacer.sv
// ela_deinterlacer: copies a frame from the input BRAM to the processing
// memory, then rewrites the odd rows with vertical-average or edge-based
// line-average (ELA) interpolation taken from the original input frame.
// A write is registered in COPY/WRITE and appears on the outputs one cycle later.
module ela_deinterlacer #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 19,
  parameter int IMG_W       = 400,
  parameter int IMG_H       = 300,
  parameter int INIT_CYCLES = 1024
) (
  input  logic                  clk_p,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cmd,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  output_valid,
  output logic                  ready,
  output logic                  busy,
  output logic                  done
);

  localparam int ICW = $clog2(INIT_CYCLES + 1);
  localparam int RW  = $clog2(IMG_H + 2);
  localparam int CW  = $clog2(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0] W_A       = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [CW-1:0]         LAST_COL  = CW'(IMG_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COPY  = 3'd1;
  localparam logic [2:0] S_NEXT  = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            r_state;
  logic [ICW-1:0]        r_initCnt;
  logic [1:0]            r_mode;
  logic                  r_issue;
  logic                  r_v1;
  logic [ADDR_WIDTH-1:0] r_a1;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic [ADDR_WIDTH-1:0] r_loc;
  logic                  r_isEla;
  logic [2:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_pix [0:5];

  logic                  w_accept;
  logic                  w_elaNow;
  logic                  w_lastRow;
  logic [2:0]            w_fetchLen;
  logic [ADDR_WIDTH-1:0] w_firstAddr;
  logic [ADDR_WIDTH-1:0] w_nextAddr;
  logic [DATA_WIDTH-1:0] w_dL, w_dV, w_dR;
  logic [DATA_WIDTH-1:0] w_selA, w_selB;
  logic [DATA_WIDTH-1:0] w_result;

  // Neighbour address for read slot idx; ELA order is L-W-1, L+W+1, L-W, L+W, L-W+1, L+W-1
  function automatic logic [ADDR_WIDTH-1:0] fetchAddr(input logic [ADDR_WIDTH-1:0] loc,
                                                      input logic ela,
                                                      input logic [2:0] idx);
    logic [ADDR_WIDTH-1:0] a;
    if (ela) begin
      case (idx)
        3'd0:    a = loc - W_A - ONE_A;
        3'd1:    a = loc + W_A + ONE_A;
        3'd2:    a = loc - W_A;
        3'd3:    a = loc + W_A;
        3'd4:    a = loc - W_A + ONE_A;
        default: a = loc + W_A - ONE_A;
      endcase
    end else begin
      a = (idx == 3'd0) ? loc - W_A : loc + W_A;
    end
    return a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] absDiff(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  assign w_accept    = start && ready && !busy && (r_state == S_IDLE);
  assign w_elaNow    = (r_mode == 2'd2) && (r_col != '0) && (r_col != LAST_COL);
  assign w_lastRow   = (int'(r_row) + 1 >= IMG_H);
  assign w_fetchLen  = r_isEla ? 3'd6 : 3'd2;
  assign w_firstAddr = fetchAddr(r_loc, w_elaNow, 3'd0);
  assign w_nextAddr  = fetchAddr(r_loc, r_isEla, r_cnt + 3'd1);
  assign w_dL        = absDiff(r_pix[0], r_pix[1]);
  assign w_dV        = absDiff(r_pix[2], r_pix[3]);
  assign w_dR        = absDiff(r_pix[4], r_pix[5]);
  assign w_result    = DATA_WIDTH'(({1'b0, w_selA} + {1'b0, w_selB}) >> 1);

  // Pick the pixel pair to average: vertical wins ties, then left, then right
  always_comb begin
    w_selA = r_pix[0];
    w_selB = r_pix[1];
    if (r_isEla) begin
      if ((w_dV <= w_dL) && (w_dV <= w_dR)) begin
        w_selA = r_pix[2];
        w_selB = r_pix[3];
      end else if (w_dL > w_dR) begin
        w_selA = r_pix[4];
        w_selB = r_pix[5];
      end
    end
  end

  // Power-up delay: ready goes high INIT_CYCLES cycles after reset and stays high
  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      r_initCnt <= '0;
      ready     <= 1'b0;
    end else if (!ready) begin
      if (r_initCnt == ICW'(INIT_CYCLES - 1)) ready <= 1'b1;
      else                                    r_initCnt <= r_initCnt + 1'b1;
    end
  end

  // Frame sequencer: copy pass, then one NEXT/FETCH/WRITE round per interpolated pixel
  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'd0;
      r_issue      <= 1'b0;
      r_v1         <= 1'b0;
      r_a1         <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_loc        <= '0;
      r_isEla      <= 1'b0;
      r_cnt        <= '0;
      for (int i = 0; i < 6; i++) r_pix[i] <= '0;
      w_addr       <= '0;
      o_addr       <= '0;
      data_out     <= '0;
      output_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_COPY;
            busy    <= 1'b1;
            r_mode  <= (cmd == 2'd3) ? 2'd0 : cmd;
            w_addr  <= '0;
            r_issue <= 1'b1;
            r_v1    <= 1'b0;
            r_row   <= RW'(1);
            r_col   <= '0;
            r_loc   <= W_A;
          end
        end
        S_COPY: begin
          if (r_issue) begin
            if (w_addr == LAST_ADDR) r_issue <= 1'b0;
            else                     w_addr  <= w_addr + ONE_A;
          end
          r_v1 <= r_issue;
          r_a1 <= w_addr;
          if (r_v1) begin
            output_valid <= 1'b1;
            o_addr       <= r_a1;
            data_out     <= data_in;
            if (r_a1 == LAST_ADDR) r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if ((r_mode == 2'd0) || w_lastRow) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            w_addr  <= w_firstAddr;
            r_isEla <= w_elaNow;
            r_cnt   <= 3'd0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_cnt != 3'd0) r_pix[r_cnt - 3'd1] <= data_in;
          if (r_cnt == w_fetchLen) begin
            r_state <= S_WRITE;
          end else begin
            if ((r_cnt + 3'd1) < w_fetchLen) w_addr <= w_nextAddr;
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_WRITE: begin
          output_valid <= 1'b1;
          o_addr       <= r_loc;
          data_out     <= w_result;
          if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + RW'(2);
            r_loc <= r_loc + W_A + ONE_A;
          end else begin
            r_col <= r_col + 1'b1;
            r_loc <= r_loc + ONE_A;
          end
          r_state <= S_NEXT;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
